// File: rtl/ci_sum_initiator.sv
// Requester side of the multi-cycle custom-instruction handshake: one accelerator
// transaction per accepted command, with the result (or an error) returned on a response port.
module ci_sum_initiator #(
  parameter int FLT_DATA_WIDTH = 32,
  parameter int N_WIDTH        = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMER_WIDTH    = 11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [N_WIDTH-1:0]        cmd_n,
  input  logic [FLT_DATA_WIDTH-1:0] cmd_x_one,
  input  logic [FLT_DATA_WIDTH-1:0] cmd_x_two,
  input  logic [FLT_DATA_WIDTH-1:0] cmd_x_three,
  output logic                      ci_clk_en,
  output logic                      ci_start,
  output logic [N_WIDTH-1:0]        ci_n,
  output logic [FLT_DATA_WIDTH-1:0] ci_x_one,
  output logic [FLT_DATA_WIDTH-1:0] ci_x_two,
  output logic [FLT_DATA_WIDTH-1:0] ci_x_three,
  input  logic                      ci_done,
  input  logic [FLT_DATA_WIDTH-1:0] ci_result,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [FLT_DATA_WIDTH-1:0] rsp_data,
  output logic                      rsp_err,
  output logic                      busy
);

  localparam logic [N_WIDTH-1:0]     OP_RESERVED  = N_WIDTH'(3);
  localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESPOND} state_t;

  state_t                      r_state;
  state_t                      w_state_next;
  logic [N_WIDTH-1:0]          r_n;
  logic [FLT_DATA_WIDTH-1:0]   r_x_one;
  logic [FLT_DATA_WIDTH-1:0]   r_x_two;
  logic [FLT_DATA_WIDTH-1:0]   r_x_three;
  logic [TIMER_WIDTH-1:0]      r_timer;
  logic [FLT_DATA_WIDTH-1:0]   r_rsp_data;
  logic                        r_rsp_err;
  logic                        w_cmd_fire;
  logic                        w_reserved;
  logic                        w_timeout;

  assign w_cmd_fire = cmd_valid && cmd_ready;
  assign w_reserved = (cmd_n == OP_RESERVED);
  assign w_timeout  = (r_timer == TIMEOUT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_cmd_fire) w_state_next = w_reserved ? S_RESPOND : S_ISSUE;
      S_ISSUE:   w_state_next = S_WAIT;
      S_WAIT:    if (ci_done || w_timeout) w_state_next = S_RESPOND;
      S_RESPOND: if (rsp_ready) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (r_state == S_IDLE) && !rst;
    ci_start  = (r_state == S_ISSUE);
    ci_clk_en = (r_state == S_ISSUE) || (r_state == S_WAIT);
    busy      = (r_state == S_ISSUE) || (r_state == S_WAIT);
    rsp_valid = (r_state == S_RESPOND);
  end

  // Done wins over timeout in the same cycle; done seen outside WAIT never touches the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n        <= '0;
      r_x_one    <= '0;
      r_x_two    <= '0;
      r_x_three  <= '0;
      r_timer    <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cmd_fire) begin
            r_n       <= cmd_n;
            r_x_one   <= cmd_x_one;
            r_x_two   <= cmd_x_two;
            r_x_three <= cmd_x_three;
            if (w_reserved) begin
              r_rsp_data <= '0;
              r_rsp_err  <= 1'b1;
            end
          end
        end
        S_ISSUE: r_timer <= '0;
        S_WAIT: begin
          if (ci_done) begin
            r_rsp_data <= ci_result;
            r_rsp_err  <= 1'b0;
          end else if (w_timeout) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ci_n       = r_n;
  assign ci_x_one   = r_x_one;
  assign ci_x_two   = r_x_two;
  assign ci_x_three = r_x_three;
  assign rsp_data   = r_rsp_data;
  assign rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_ci_sum_initiator.sv
// Randomized self-checking bench for ci_sum_initiator; the bench plays both the
// command source and the accelerator, and predicts each response from the opcode and done delay.
module tb_ci_sum_initiator;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_n;
  logic [31:0] cmd_x_one, cmd_x_two, cmd_x_three;
  logic        ci_clk_en, ci_start;
  logic [1:0]  ci_n;
  logic [31:0] ci_x_one, ci_x_two, ci_x_three;
  logic        ci_done;
  logic [31:0] ci_result;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err, busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]  pre_n;
  logic [31:0] pre_x1, pre_x2, pre_x3;

  ci_sum_initiator #(
    .FLT_DATA_WIDTH(32), .N_WIDTH(2), .TIMEOUT_CYCLES(TMO), .TIMER_WIDTH(5)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_n(cmd_n),
    .cmd_x_one(cmd_x_one), .cmd_x_two(cmd_x_two), .cmd_x_three(cmd_x_three),
    .ci_clk_en(ci_clk_en), .ci_start(ci_start), .ci_n(ci_n),
    .ci_x_one(ci_x_one), .ci_x_two(ci_x_two), .ci_x_three(ci_x_three),
    .ci_done(ci_done), .ci_result(ci_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
    end
  endtask

  // Reference: reserved opcode or no done within TMO wait cycles -> error with zero data.
  function automatic logic [32:0] model_rsp(input logic [1:0] n, input int k, input logic [31:0] res);
    if (n == 2'd3) return {1'b1, 32'h0};
    if (k >= 1 && k <= TMO) return {1'b0, res};
    return {1'b1, 32'h0};
  endfunction

  // k = cycles after the ISSUE cycle at which done is driven (outside 1..TMO means never in time).
  task automatic do_cmd(input logic [1:0] n, input logic [31:0] x1, input logic [31:0] x2,
                        input logic [31:0] x3, input logic [31:0] res, input int k,
                        input bit early, input int hold, input bit preload);
    logic [32:0] want;
    logic [31:0] got_data;
    logic        got_err;
    int          last;
    bit          stray;
    want  = model_rsp(n, k, res);
    stray = (n != 2'd3) && !(k >= 1 && k <= TMO);
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    cmd_valid = 1'b1; cmd_n = n; cmd_x_one = x1; cmd_x_two = x2; cmd_x_three = x3;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (n == 2'd3) begin
      check("rsv_rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsv_no_start", 32'(ci_start), 32'd0);
      check("rsv_clk_en", 32'(ci_clk_en), 32'd0);
    end else begin
      check("issue_start", 32'(ci_start), 32'd1);
      check("issue_clk_en", 32'(ci_clk_en), 32'd1);
      check("issue_n", 32'(ci_n), 32'(n));
      check("issue_x1", ci_x_one, x1);
      check("issue_busy", 32'(busy), 32'd1);
      ci_done   = early;
      ci_result = $urandom;
      last = (k >= 1 && k <= TMO) ? k : TMO;
      for (int c = 1; c <= last; c++) begin
        @(negedge clk);
        check("wait_start", 32'(ci_start), 32'd0);
        check("wait_clk_en", 32'(ci_clk_en), 32'd1);
        check("wait_n", 32'(ci_n), 32'(n));
        check("wait_x1", ci_x_one, x1);
        check("wait_x2", ci_x_two, x2);
        check("wait_x3", ci_x_three, x3);
        check("wait_rsp_valid", 32'(rsp_valid), 32'd0);
        ci_done   = (c == k);
        ci_result = (c == k) ? res : $urandom;
      end
      @(negedge clk);
    end
    got_data = rsp_data;
    got_err  = rsp_err;
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) @(negedge clk);
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_data", rsp_data, want[31:0]);
      check("rsp_err", 32'(rsp_err), 32'(want[32]));
      check("rsp_cmd_ready", 32'(cmd_ready), 32'd0);
      check("rsp_clk_en", 32'(ci_clk_en), 32'd0);
      check("rsp_busy", 32'(busy), 32'd0);
      ci_done   = (h == 0) && stray;
      ci_result = $urandom;
      if (preload && h == 0) begin
        cmd_valid = 1'b1; cmd_n = pre_n;
        cmd_x_one = pre_x1; cmd_x_two = pre_x2; cmd_x_three = pre_x3;
      end
      rsp_ready = (h == hold);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    ci_done   = 1'b0;
    check("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_cmd_ready", 32'(cmd_ready), 32'd1);
    $display("txn n=%0d k=%0d early=%0d hold=%0d data=%h err=%0d", n, k, early, hold, got_data, got_err);
  endtask

  task automatic reset_abort();
    cmd_valid = 1'b1; cmd_n = 2'd1;
    cmd_x_one = $urandom; cmd_x_two = $urandom; cmd_x_three = $urandom;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_start", 32'(ci_start), 32'd0);
    check("rst_clk_en", 32'(ci_clk_en), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_ci_n", 32'(ci_n), 32'd0);
    check("rst_x1", ci_x_one, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ci_done = 1'b1; ci_result = $urandom;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ci_done = 1'b0;
      check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    end
    $display("txn reset_abort in WAIT cycle 3");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rn;
    rst = 1'b1; cmd_valid = 1'b0; cmd_n = '0;
    cmd_x_one = '0; cmd_x_two = '0; cmd_x_three = '0;
    ci_done = 1'b0; ci_result = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_cmd_ready", 32'(cmd_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_clk_en", 32'(ci_clk_en), 32'd0);
    check("reset_rsp_data", rsp_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_cmd(2'd1, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h41000000, 5, 1'b0, 0, 1'b0);
    do_cmd(2'd3, $urandom, $urandom, $urandom, $urandom, 1, 1'b0, 0, 1'b0);
    do_cmd(2'd1, $urandom, $urandom, $urandom, $urandom, 99, 1'b0, 0, 1'b0);
    pre_n = 2'd0; pre_x1 = $urandom; pre_x2 = $urandom; pre_x3 = $urandom;
    do_cmd(2'd2, $urandom, $urandom, $urandom, $urandom, 3, 1'b0, 10, 1'b1);
    do_cmd(pre_n, pre_x1, pre_x2, pre_x3, $urandom, 2, 1'b0, 0, 1'b0);
    reset_abort();
    do_cmd(2'd1, $urandom, $urandom, $urandom, $urandom, 4, 1'b0, 0, 1'b0);
    do_cmd(2'd0, $urandom, $urandom, $urandom, $urandom, 2, 1'b1, 0, 1'b0);
    do_cmd(2'd1, $urandom, $urandom, $urandom, $urandom, 2, 1'b1, 0, 1'b0);
    do_cmd(2'd2, $urandom, $urandom, $urandom, $urandom, 2, 1'b1, 0, 1'b0);
    do_cmd(2'd1, $urandom, $urandom, $urandom, $urandom, TMO, 1'b0, 0, 1'b0);
    do_cmd(2'd1, $urandom, $urandom, $urandom, $urandom, TMO + 1, 1'b0, 0, 1'b0);
    do_cmd(2'd0, $urandom, $urandom, $urandom, $urandom, 1, 1'b1, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      rn = 2'($urandom_range(0, 3));
      do_cmd(rn, $urandom, $urandom, $urandom, $urandom, $urandom_range(1, 20),
             1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
